mul_feeder: RTL and testbench

MUL_FEEDER -- requirements
Module: mul_feeder

---
 rtl/mul_feeder.sv | 162 ++++++++++++++++
 tb/tb_mul_feeder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_feeder.sv
// Operand feeder for an iterative 8x8 multiplier. Operand pairs are queued in a small FIFO.
// Each pair is handed to the multiplier with a one-cycle start pulse. The 16-bit product
// is captured and held for a valid/ready downstream consumer.
module mul_feeder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  // operand stream
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  // multiplier side
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_ready,
  input  logic [15:0] mul_out,
  // result stream
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait0,
    StWait,
    StHold
  } state_e;

  state_e state_q, state_d;

  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic          push, pop;
  logic          load_ops, capture, accept;

  logic          mul_start_q;
  logic [7:0]    mul_a_q, mul_b_q;
  logic [15:0]   res_q;
  logic          res_valid_q;

  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // The head leaves the FIFO during the START cycle; its operands were latched on entry.
  assign pop      = (state_q == StStart);

  // FIFO storage; no reset needed, entries are only read after being written
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr_q] <= in_a;
      mem_b[wptr_q] <= in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and datapath strobes
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StStart;
      end
      StStart: begin
        state_d = StWait0;
      end
      // mul_ready may still be high from the previous product here, so it is not looked at.
      StWait0: begin
        state_d = StWait;
      end
      StWait: begin
        if (mul_ready) begin
          capture = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (res_ready) begin
          accept  = 1'b1;
          state_d = (count_q != '0) ? StStart : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    load_ops = (state_d == StStart);
  end

  // Multiplier interface registers: start pulse and operands latched on entry to START
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      mul_start_q <= load_ops;
      if (load_ops) begin
        mul_a_q <= mem_a[rptr_q];
        mul_b_q <= mem_b[rptr_q];
      end
    end
  end

  // Result register: captured once per product and held until the consumer takes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (capture) begin
        res_q       <= mul_out;
        res_valid_q <= 1'b1;
      end else if (accept) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_mul_feeder.sv
// Directed bench for mul_feeder with a behavioural iterative multiplier whose ready stays
// high (stale) for two cycles after a start before dropping for the configured latency.
module tb_mul_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic        mul_start;
  logic [7:0]  mul_a, mul_b;
  logic        mul_ready;
  logic [15:0] mul_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_res[$];
  logic [15:0] exp_op[$];

  mul_feeder #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_ready (mul_ready),
    .mul_out   (mul_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res)
  );

  always #5 clk = ~clk;

  // Multiplier model: not reset by the feeder, keeps running across a feeder reset.
  logic [7:0]  m_a = 8'd0, m_b = 8'd0;
  logic [15:0] m_prod = 16'd0;
  int          m_cnt = 0;
  logic        m_pend = 1'b0;
  int          m_lat = 8;

  always @(posedge clk) begin
    if (mul_start) begin
      m_a    <= mul_a;
      m_b    <= mul_b;
      m_pend <= 1'b1;
    end else if (m_pend) begin
      m_pend <= 1'b0;
      m_cnt  <= m_lat;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_prod <= 16'(m_a) * 16'(m_b);
    end
  end

  assign mul_ready = (m_cnt == 0);
  assign mul_out   = m_prod;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: operand order, start pulse shape, result order, valid drop after acceptance.
  logic prev_start = 1'b0;
  logic prev_acc   = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_start <= 1'b0;
      prev_acc   <= 1'b0;
    end else begin
      if (mul_start) begin
        check("start_consec", 32'(prev_start), 0);
        if (exp_op.size() == 0) begin
          check("op_unexp", 32'(mul_start), 0);
        end else begin
          check("mul_ops", 32'({mul_a, mul_b}), 32'(exp_op.pop_front()));
        end
      end
      if (prev_acc) check("valid_fall", 32'(res_valid), 0);
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) begin
          check("res_unexp", 32'(res_valid), 0);
        end else begin
          check("res", 32'(res), 32'(exp_res.pop_front()));
        end
      end
      prev_start <= mul_start;
      prev_acc   <= res_valid && res_ready;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    logic rdy;
    bit   done;
    done     = 1'b0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      if (rdy) begin
        exp_op.push_back({a, b});
        exp_res.push_back(p);
      end
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 32'(done), 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600 && exp_res.size() != 0; i++) @(posedge clk);
    check("drain_res", 32'(exp_res.size()), 0);
    check("drain_op", 32'(exp_op.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge clk);
    check("valid_seen", 32'(res_valid), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_st, n_rv;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_mul_start", 32'(mul_start), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);
    check("rst_res", 32'(res), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single product, then full-range and zero products in order.
    res_ready = 1'b1;
    push(8'd3, 8'd5, 16'd15);
    wait_drain();
    push(8'd255, 8'd255, 16'd65025);
    push(8'd0, 8'd200, 16'd0);
    wait_drain();

    // Short multiplier latency.
    m_lat = 1;
    push(8'd12, 8'd13, 16'd156);
    push(8'd200, 8'd100, 16'd20000);
    wait_drain();
    m_lat = 8;

    // Back-pressure: one pair in flight plus four queued fills the FIFO.
    res_ready = 1'b0;
    push(8'd1, 8'd1, 16'd1);
    push(8'd2, 8'd2, 16'd4);
    push(8'd3, 8'd3, 16'd9);
    push(8'd4, 8'd4, 16'd16);
    push(8'd5, 8'd5, 16'd25);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 0);
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_res", 32'(res), 1);
      check("hold_valid", 32'(res_valid), 1);
      check("hold_full", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    push(8'd6, 8'd6, 16'd36);
    wait_drain();

    // Push in the same cycle START pops with three queued.
    res_ready = 1'b0;
    push(8'd1, 8'd2, 16'd2);
    push(8'd2, 8'd2, 16'd4);
    push(8'd3, 8'd3, 16'd9);
    push(8'd3, 8'd4, 16'd12);
    wait_valid();
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1;
    in_a     = 8'd5;
    in_b     = 8'd5;
    in_valid = 1'b1;
    exp_op.push_back({8'd5, 8'd5});
    exp_res.push_back(16'd25);
    @(negedge clk);
    check("pop_start", 32'(mul_start), 1);
    check("pop_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("cnt_same", 32'(in_ready), 1);
    wait_drain();

    // Reset while waiting on the multiplier with two pairs queued.
    push(8'd7, 8'd7, 16'd49);
    push(8'd2, 8'd3, 16'd6);
    push(8'd4, 8'd4, 16'd16);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    exp_res.delete();
    exp_op.delete();
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    check("mid_rst_start", 32'(mul_start), 0);
    check("mid_rst_ops", 32'({mul_a, mul_b}), 0);
    check("mid_rst_res", 32'(res), 0);
    check("mid_rst_valid", 32'(res_valid), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    n_st = 0;
    n_rv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mul_start) n_st++;
      if (res_valid) n_rv++;
    end
    check("post_rst_ready", 32'(mul_ready), 1);
    check("post_rst_starts", 32'(n_st), 0);
    check("post_rst_valids", 32'(n_rv), 0);
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Normal operation resumes after reset.
    @(posedge clk);
    #1;
    push(8'd9, 8'd9, 16'd81);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
